// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 32;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins; on a tie the port that did
// not win last time is chosen.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic sel
);

  always_comb begin
    gnt_valid = req0 | req1;
    sel       = P0;
    if (req0 && req1) begin
      sel = ~last_grant;
    end else if (req1) begin
      sel = P1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port registered-read RAM between two req/done requesters,
// one access every four cycles, round-robin between the ports.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata stable and keeps them
  // so until its done pulse; it drops req (or changes the request) on the edge
  // after done. A req still high when the FSM is back in IDLE is a new access.

  state_e          state_q, state_d;
  logic            sel_q, sel_d;
  logic            acc_we_q, acc_we_d;
  logic            last_grant_q, last_grant_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_din_q, ram_din_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            gnt_valid;
  logic            gnt_sel;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .sel        (gnt_sel)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    acc_we_d     = acc_we_q;
    last_grant_d = last_grant_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = ISSUE;
          sel_d        = gnt_sel;
          last_grant_d = gnt_sel;
          if (gnt_sel == P1) begin
            ram_we_d   = we1;
            ram_addr_d = addr1;
            ram_din_d  = wdata1;
            acc_we_d   = we1;
          end else begin
            ram_we_d   = we0;
            ram_addr_d = addr0;
            ram_din_d  = wdata0;
            acc_we_d   = we0;
          end
        end
      end
      ISSUE: begin
        // The RAM samples the write at the end of this cycle; never write twice.
        ram_we_d = 1'b0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (!acc_we_q) begin
          if (sel_q == P1) begin
            rdata1_d = ram_dout;
          end else begin
            rdata0_d = ram_dout;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= P0;
      acc_we_q     <= 1'b0;
      last_grant_q <= P1;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      acc_we_q     <= acc_we_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign done0     = (state_q == DONE) && (sel_q == P0);
  assign done1     = (state_q == DONE) && (sel_q == P1);
  assign busy      = (state_q != IDLE);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 128x32 RAM and an
// expected-done queue checked by an independent monitor.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int EW = 50; // {done cycle[15:0], port, check_rdata, data[31:0]}

  logic          clka = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, busy, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbg_state;

  logic [DW-1:0] mem [128];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [EW-1:0] exp_q[$];

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clka      (clka),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done0     (done0),
    .done1     (done1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter / RAM model ----------------
  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h5A5A_0000 + i;
  end

  always @(posedge clka) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic expect_done(input int c, input logic port, input logic chk, input logic [31:0] d);
    exp_q.push_back({16'(c), port, chk, d});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clka) begin
    logic [EW-1:0] e;
    if (done0 || done1) begin
      check("done_exclusive", {31'b0, done0 & done1}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done0=%0b done1=%0b with empty queue (cycle %0d)",
                 done0, done1, cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 32'(cyc[15:0]), {16'd0, e[49:34]});
        check("done_port", {31'b0, done1}, {31'b0, e[33]});
        if (e[32]) check("rdata", done1 ? rdata1 : rdata0, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    step_to(3);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {30'b0, done1, done0}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_ram_addr", {25'b0, ram_addr}, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'(IDLE));
    rst = 1'b0;
    step_to(cyc + 1);

    // Test 1: port 0 write addr 2
    n = cyc;
    req0 = 1; we0 = 1; addr0 = 7'd2; wdata0 = 32'h1234_4321;
    expect_done(n + 3, P0, 1'b0, 32'd0);
    step_to(n + 1);
    check("t1_issue_state", {30'b0, dbg_state}, 32'(ISSUE));
    check("t1_issue_we", {31'b0, ram_we}, 32'd1);
    check("t1_issue_addr", {25'b0, ram_addr}, 32'd2);
    check("t1_issue_din", ram_din, 32'h1234_4321);
    check("t1_busy", {31'b0, busy}, 32'd1);
    step_to(n + 2);
    check("t1_wait_we", {31'b0, ram_we}, 32'd0);
    step_to(n + 4);
    req0 = 0; we0 = 0;

    // Test 2: port 1 reads back addr 2; rdata0 untouched
    n = cyc;
    req1 = 1; we1 = 0; addr1 = 7'd2;
    expect_done(n + 3, P1, 1'b1, 32'h1234_4321);
    step_to(n + 3);
    check("t2_rdata0_held", rdata0, 32'd0);
    step_to(n + 4);
    req1 = 0;

    // Test 3: simultaneous reads, port 0 first (last grant was port 1)
    n = cyc;
    req0 = 1; we0 = 0; addr0 = 7'd2;
    req1 = 1; we1 = 0; addr1 = 7'd5;
    expect_done(n + 3, P0, 1'b1, 32'h1234_4321);
    expect_done(n + 7, P1, 1'b1, 32'h5A5A_0005);
    step_to(n + 4);
    req0 = 0;
    step_to(n + 8);
    req1 = 0;

    // Test 4: both held for six accesses, grants alternate 0,1,...
    n = cyc;
    req0 = 1; we0 = 0; addr0 = 7'd10;
    req1 = 1; we1 = 0; addr1 = 7'd11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) expect_done(n + 3 + 4 * k, P0, 1'b1, 32'h5A5A_000A);
      else            expect_done(n + 3 + 4 * k, P1, 1'b1, 32'h5A5A_000B);
    end
    for (int k = 1; k <= 24; k++) begin
      step_to(n + k);
      check("t4_busy", {31'b0, busy}, (k % 4 != 0) ? 32'd1 : 32'd0);
    end
    req0 = 0; req1 = 0;

    // Test 5: reset during WAIT of a read
    n = cyc;
    req0 = 1; we0 = 0; addr0 = 7'd3;
    step_to(n + 2);
    check("t5_in_wait", {30'b0, dbg_state}, 32'(WAIT));
    rst = 1'b1;
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_done", {30'b0, done1, done0}, 32'd0);
    check("t5_ram_we", {31'b0, ram_we}, 32'd0);
    check("t5_ram_addr", {25'b0, ram_addr}, 32'd0);
    check("t5_ram_din", ram_din, 32'd0);
    check("t5_rdata", rdata0 | rdata1, 32'd0);
    req0 = 0;
    step_to(n + 5);
    rst = 1'b0;
    step_to(n + 6);
    check("t5_state_after", {30'b0, dbg_state}, 32'(IDLE));
    n = cyc;
    req0 = 1; we0 = 0; addr0 = 7'd2;
    expect_done(n + 3, P0, 1'b1, 32'h1234_4321);
    step_to(n + 4);
    req0 = 0;

    // Test 6: top address write, then read top and bottom
    n = cyc;
    req1 = 1; we1 = 1; addr1 = 7'd127; wdata1 = 32'hFFFF_FFFF;
    expect_done(n + 3, P1, 1'b0, 32'd0);
    step_to(n + 4);
    req1 = 0; we1 = 0;
    n = cyc;
    req0 = 1; we0 = 0; addr0 = 7'd127;
    expect_done(n + 3, P0, 1'b1, 32'hFFFF_FFFF);
    step_to(n + 4);
    req0 = 0;
    n = cyc;
    req1 = 1; we1 = 0; addr1 = 7'd0;
    expect_done(n + 3, P1, 1'b1, 32'h5A5A_0000);
    step_to(n + 4);
    req1 = 0;

    step_to(cyc + 6);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_idle", {30'b0, dbg_state}, 32'(IDLE));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
